// File: rtl/wb_pkg.sv
// Shared Wishbone constants and arbiter FSM state encoding.
// Pure declarations: no latency, no flow control.
package wb_pkg;
    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;
endpackage

// File: rtl/wb_arb2.sv
// Two-master round-robin Wishbone arbiter onto one slave; ack timeout under WB_ARB2_TIMEOUT_EN.
// Latency: grant one edge after cyc seen in IDLE; slave signals muxed combinationally.
// Backpressure: granted master locks the bus until it drops cyc; loser waits, stalls on s_ack_i.
module wb_arb2
    import wb_pkg::*;
#(
    parameter int ADR_W   = WB_ADR_W,
    parameter int DAT_W   = WB_DAT_W,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    input  logic             m0_we_i,
    input  logic             m1_we_i,
    input  logic             m0_cyc_i,
    input  logic             m1_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m1_stb_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m0_ack_o,
    output logic             m1_ack_o,
    output logic             m0_err_o,
    output logic             m1_err_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    output logic             s_we_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i
);

    logic [1:0] r_state;
    logic [1:0] w_nxt;
    logic       r_last;     // 1: m1 served last, so m0 wins the next tie
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_tmo_hit;

    assign w_gnt0 = (r_state == ST_GNT0);
    assign w_gnt1 = (r_state == ST_GNT1);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) w_nxt = r_last ? ST_GNT0 : ST_GNT1;
                else if (m0_cyc_i)        w_nxt = ST_GNT0;
                else if (m1_cyc_i)        w_nxt = ST_GNT1;
                else                      w_nxt = ST_IDLE;
            end
            ST_GNT0: w_nxt = m0_cyc_i ? ST_GNT0 : ST_IDLE;
            ST_GNT1: w_nxt = m1_cyc_i ? ST_GNT1 : ST_IDLE;
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_nxt;
            if (r_state == ST_IDLE && w_nxt == ST_GNT0) r_last <= 1'b0;
            if (r_state == ST_IDLE && w_nxt == ST_GNT1) r_last <= 1'b1;
        end
    end

    // Dropping cyc removes stb in the same cycle, so a late slave ack is never forwarded.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        if (w_gnt0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_we_o  = m0_we_i;
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_cyc_i & m0_stb_i;
        end else if (w_gnt1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_cyc_i & m1_stb_i;
        end
    end

`ifdef WB_ARB2_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_tmo;
    logic             w_stall;

    assign w_stall   = s_stb_o & ~s_ack_i;
    assign w_tmo_hit = w_stall && (r_tmo == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo <= '0;
        end else if (!w_stall || w_tmo_hit || (w_nxt != r_state)) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign m0_err_o = w_tmo_hit & w_gnt0;
    assign m1_err_o = w_tmo_hit & w_gnt1;
`else
    assign w_tmo_hit = 1'b0;
    assign m0_err_o  = 1'b0;
    assign m1_err_o  = 1'b0;
`endif

    assign m0_ack_o = s_ack_i & s_stb_o & w_gnt0 & ~w_tmo_hit;
    assign m1_ack_o = s_ack_i & s_stb_o & w_gnt1 & ~w_tmo_hit;
    assign m0_dat_o = w_gnt0 ? s_dat_i : '0;
    assign m1_dat_o = w_gnt1 ? s_dat_i : '0;

endmodule

// File: tb/tb_wb_arb2.sv
// Directed bench for wb_arb2: reset, round-robin ties, bus lock, write routing, timeout, abort.
module tb_wb_arb2;
    import wb_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;
`ifdef WB_ARB2_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m0_adr_i, m1_adr_i;
    logic [DW-1:0] m0_dat_i, m1_dat_i;
    logic          m0_we_i, m1_we_i, m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i;
    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic          s_we_o, s_cyc_o, s_stb_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_arb2 #(.ADR_W(AW), .DAT_W(DW), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_adr_i (m0_adr_i),
        .m1_adr_i (m1_adr_i),
        .m0_dat_i (m0_dat_i),
        .m1_dat_i (m1_dat_i),
        .m0_we_i  (m0_we_i),
        .m1_we_i  (m1_we_i),
        .m0_cyc_i (m0_cyc_i),
        .m1_cyc_i (m1_cyc_i),
        .m0_stb_i (m0_stb_i),
        .m1_stb_i (m1_stb_i),
        .m0_dat_o (m0_dat_o),
        .m1_dat_o (m1_dat_o),
        .m0_ack_o (m0_ack_o),
        .m1_ack_o (m1_ack_o),
        .m0_err_o (m0_err_o),
        .m1_err_o (m1_err_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_we_o   (s_we_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        m0_adr_i = 32'h100; m1_adr_i = '0;
        m0_dat_i = '0; m1_dat_i = '0;
        m0_we_i = 1'b0; m1_we_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        s_dat_i = 32'hA5; s_ack_i = 1'b1;
        #3;
        // Reset holds all outputs low even with m0 requesting and the slave acking.
        chk("rst_s_cyc",  32'(s_cyc_o),  32'h0);
        chk("rst_s_stb",  32'(s_stb_o),  32'h0);
        chk("rst_s_adr",  s_adr_o,       32'h0);
        chk("rst_m0_ack", 32'(m0_ack_o), 32'h0);
        chk("rst_m0_dat", m0_dat_o,      32'h0);
        chk("rst_m0_err", 32'(m0_err_o), 32'h0);
        step(); step();
        chk("rst_hold_cyc", 32'(s_cyc_o), 32'h0);

        rst = 1'b1;
        #1;
        chk("rel_idle_cyc", 32'(s_cyc_o), 32'h0);
        step();
        chk("rel_gnt_cyc",  32'(s_cyc_o),  32'h1);
        chk("rel_gnt_adr",  s_adr_o,       32'h100);
        chk("rel_gnt_stb",  32'(s_stb_o),  32'h1);
        chk("rel_m0_ack",   32'(m0_ack_o), 32'h1);
        chk("rel_m0_dat",   m0_dat_o,      32'hA5);

        // Reset mid-cycle drops the slave strobe and any forwarded ack immediately.
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_cyc", 32'(s_cyc_o),  32'h0);
        chk("midrst_stb", 32'(s_stb_o),  32'h0);
        chk("midrst_ack", 32'(m0_ack_o), 32'h0);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        #1;
        rst = 1'b1;
        step();

        // Tie: m0 wins first, then alternation.
        m0_adr_i = 32'h10; m1_adr_i = 32'h20;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        chk("tie1_adr",    s_adr_o,       32'h10);
        chk("tie1_m1_ack", 32'(m1_ack_o), 32'h0);
        chk("tie1_m1_dat", m1_dat_o,      32'h0);
        m0_cyc_i = 1'b0;
        #1;
        chk("tie1_drop_cyc", 32'(s_cyc_o), 32'h0);
        step();
        m0_cyc_i = 1'b1;
        #1;
        chk("tie_idle_cyc", 32'(s_cyc_o), 32'h0);
        step();
        chk("tie2_adr",    s_adr_o,       32'h20);
        chk("tie2_m1_ack", 32'(m1_ack_o), 32'h1);
        chk("tie2_m0_ack", 32'(m0_ack_o), 32'h0);
        m1_cyc_i = 1'b0;
        step();
        m1_cyc_i = 1'b1;
        step();
        chk("tie3_adr", s_adr_o, 32'h10);
        m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
        step();

        // Lock: m0 does three read beats while m1 waits.
        m0_adr_i = 32'h0; m0_we_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        step();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h8;
        for (int i = 0; i < 3; i++) begin
            s_ack_i = 1'b1;
            #1;
            chk($sformatf("lock%0d_adr", i),    s_adr_o,       32'h0);
            chk($sformatf("lock%0d_m0_dat", i), m0_dat_o,      32'hA5);
            chk($sformatf("lock%0d_m0_ack", i), 32'(m0_ack_o), 32'h1);
            chk($sformatf("lock%0d_m1_ack", i), 32'(m1_ack_o), 32'h0);
            step();
        end
        m0_cyc_i = 1'b0;
        s_ack_i = 1'b0;
        step();
        chk("lock_rel_cyc", 32'(s_cyc_o), 32'h0);
        m1_we_i = 1'b1; m1_dat_i = 32'h0F;
        step();

        // Write routing for m1.
        chk("wr_adr",     s_adr_o,       32'h8);
        chk("wr_dat",     s_dat_o,       32'h0F);
        chk("wr_we",      32'(s_we_o),   32'h1);
        chk("wr_ack_lo",  32'(m1_ack_o), 32'h0);
        s_ack_i = 1'b1;
        #1;
        chk("wr_ack_hi",  32'(m1_ack_o), 32'h1);
        s_ack_i = 1'b0;
        #1;
        chk("wr_ack_fall", 32'(m1_ack_o), 32'h0);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        step();

        // Timeout: err pulses on the 4th stalled strobe cycle only when enabled.
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("tmo%0d_m0_err", i), 32'(m0_err_o), 32'(TMO_EN && (i == 3)));
            chk($sformatf("tmo%0d_m1_err", i), 32'(m1_err_o), 32'h0);
            step();
        end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();

        // Abort: m0 drops cyc with a beat pending; late ack ignored, m1 granted after IDLE.
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        step();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h30;
        step();
        chk("abt_pre_stb", 32'(s_stb_o), 32'h1);
        m0_cyc_i = 1'b0;
        s_ack_i = 1'b1;
        #1;
        chk("abt_stb",    32'(s_stb_o),  32'h0);
        chk("abt_m0_ack", 32'(m0_ack_o), 32'h0);
        step();
        chk("abt_idle_cyc", 32'(s_cyc_o), 32'h0);
        chk("abt_idle_ack", 32'(m1_ack_o), 32'h0);
        step();
        chk("abt_m1_adr", s_adr_o,       32'h30);
        chk("abt_m1_ack", 32'(m1_ack_o), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
